// File: rtl/mem_map_bus_decoder.sv
// mem_map_bus_decoder
//   Registered memory-map decoder between the uP data port and N memory-mapped
//   slaves. A request is decoded against a table of address windows, then one
//   slave is driven until it signals s_ready or the wait budget runs out, and a
//   single-cycle response strobe is returned. Unmapped, misaligned and
//   read-only-write accesses are answered with an error and never reach a slave.
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     req_valid/req_ready  uP request handshake
//     req_write            1 = write, 0 = read
//     req_addr, req_wdata  byte address and write data
//     rsp_valid            one-cycle response strobe
//     rsp_rdata, rsp_err   read data (0 for writes/errors) and error flag
//     s_sel                one-hot slave select
//     s_addr               word offset inside the selected window
//     s_wdata, s_write     write data and write strobe to the slave
//     s_rdata              flattened slave read data, slot i = [32*i +: 32]
//     s_ready              per-slave access-complete strobe
module mem_map_bus_decoder #(
  parameter int unsigned              N_SLAVES    = 4,
  parameter logic [N_SLAVES*32-1:0]   REGION_BASE = {N_SLAVES{32'h1001_0000}},
  parameter logic [N_SLAVES*32-1:0]   REGION_SIZE = {N_SLAVES{32'h0000_0100}},
  parameter logic [N_SLAVES-1:0]      REGION_RO   = '0,
  parameter int unsigned              TIMEOUT     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [N_SLAVES-1:0]      s_sel,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic                     s_write,
  input  logic [N_SLAVES*32-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]      s_ready
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [N_SLAVES-1:0] s_sel_q, s_sel_d;
  logic [31:0]         s_addr_q, s_addr_d;
  logic [31:0]         s_wdata_q, s_wdata_d;
  logic                s_write_q, s_write_d;

  logic [N_SLAVES-1:0] dec_hit;
  logic                dec_found;
  logic                dec_ro;
  logic [31:0]         dec_off;
  logic                dec_err;

  logic [31:0]         sel_rdata;
  logic                sel_ready;
  logic                timeout_hit;

  // Window decode; 33-bit compares so a window ending at 2^32 does not wrap.
  // Scanning upward and stopping at the first hit makes the lowest index win.
  always_comb begin
    dec_hit   = '0;
    dec_found = 1'b0;
    dec_ro    = 1'b0;
    dec_off   = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (!dec_found &&
          ({1'b0, req_addr} >= {1'b0, REGION_BASE[32*i +: 32]}) &&
          ({1'b0, req_addr} <  ({1'b0, REGION_BASE[32*i +: 32]} +
                                {1'b0, REGION_SIZE[32*i +: 32]}))) begin
        dec_found  = 1'b1;
        dec_hit[i] = 1'b1;
        dec_ro     = REGION_RO[i];
        dec_off    = (req_addr - REGION_BASE[32*i +: 32]) >> 2;
      end
    end
    dec_err = !dec_found || (req_addr[1:0] != 2'b00) || (req_write && dec_ro);
  end

  // Read data and ready of the currently selected slave only.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (s_sel_q[i]) begin
        sel_rdata = s_rdata[32*i +: 32];
        sel_ready = s_ready[i];
      end
    end
  end

  // cnt_q counts completed wait cycles, so the budget is exhausted at the end
  // of the cycle in which it would step to TIMEOUT.
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == (TIMEOUT - 32'd1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    s_sel_d     = s_sel_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_write_d   = s_write_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          s_addr_d  = dec_off;
          s_wdata_d = req_wdata;
          cnt_d     = '0;
          if (dec_err) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            s_sel_d     = '0;
            s_write_d   = 1'b0;
          end else begin
            state_d   = ST_ACCESS;
            s_sel_d   = dec_hit;
            s_write_d = req_write;
          end
        end
      end

      ST_ACCESS: begin
        // A ready in the timeout cycle still completes normally.
        if (sel_ready) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = s_write_q ? 32'd0 : sel_rdata;
          s_sel_d     = '0;
          s_write_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          s_sel_d     = '0;
          s_write_d   = 1'b0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        s_sel_d   = '0;
        s_write_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      s_sel_q     <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_write_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      s_sel_q     <= s_sel_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_write_q   <= s_write_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign s_sel     = s_sel_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_write   = s_write_q;

endmodule
